// File: rtl/div_iter_unit_pkg.sv
// Shared state encodings and per-operation flag bundle for the iterative divider.
package div_iter_unit_pkg;

  localparam int unsigned DIV_ST_W = 2;

  typedef enum logic [DIV_ST_W-1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic sign_q;
    logic sign_r;
    logic is_mod;
  } div_op_t;

  // Truncating division: quotient sign is the xor of operand signs, remainder follows the dividend.
  function automatic div_op_t div_decode_op(input logic is_signed, input logic a_msb,
                                            input logic b_msb, input logic is_mod);
    div_op_t op;
    op.sign_q = is_signed & (a_msb ^ b_msb);
    op.sign_r = is_signed & a_msb;
    op.is_mod = is_mod;
    return op;
  endfunction

endpackage

// File: rtl/div_iter_unit_step.sv
// One restoring radix-2 division step on unsigned magnitudes; purely combinational.
module div_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           take;

  // rem_i < div_i always holds, so the borrow bit alone decides whether the subtract fits.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, div_i};
    take    = ~diff[WIDTH];
    rem_o   = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], take};
  end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative signed/unsigned DIV/MOD unit with valid/ready handshake, flush and tag sideband.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic             in_mod,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  div_op_t          op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             busy_q, busy_d;

  logic             accept;
  div_op_t          in_op;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             b_zero;
  logic             ovf;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign in_ready = ~flush & ((state_q == DIV_ST_IDLE) |
                              ((state_q == DIV_ST_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  // Request decode: magnitudes, sign flags and the results that bypass the iteration.
  always_comb begin
    in_op  = div_decode_op(in_signed, in_a[WIDTH-1], in_b[WIDTH-1], in_mod);
    a_abs  = (in_signed & in_a[WIDTH-1]) ? (~in_a + WIDTH'(1)) : in_a;
    b_abs  = (in_signed & in_b[WIDTH-1]) ? (~in_b + WIDTH'(1)) : in_b;
    b_zero = (in_b == '0);
    ovf    = in_signed & (in_a == MIN_VAL) & (in_b == '1);
    if (b_zero) begin
      special_res = in_mod ? in_a : '1;
    end else begin
      special_res = in_mod ? '0 : MIN_VAL;
    end
  end

  div_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign quo_fix = op_q.sign_q ? (~step_quo + WIDTH'(1)) : step_quo;
  assign rem_fix = op_q.sign_r ? (~step_rem + WIDTH'(1)) : step_rem;

  // Next-state and datapath updates; accept overrides the DONE release, flush overrides all.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    div_d        = div_q;
    op_d         = op_q;
    tag_d        = tag_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;

    unique case (state_q)
      DIV_ST_IDLE: begin
        out_valid_d = 1'b0;
      end
      DIV_ST_CALC: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d      = DIV_ST_DONE;
          out_valid_d  = 1'b1;
          out_result_d = op_q.is_mod ? rem_fix : quo_fix;
          out_tag_d    = tag_q;
        end
      end
      DIV_ST_DONE: begin
        if (out_ready) begin
          state_d     = DIV_ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = DIV_ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (accept) begin
      quo_d = a_abs;
      div_d = b_abs;
      rem_d = '0;
      op_d  = in_op;
      tag_d = in_tag;
      if (b_zero | ovf) begin
        state_d      = DIV_ST_DONE;
        cnt_d        = '0;
        out_valid_d  = 1'b1;
        out_result_d = special_res;
        out_tag_d    = in_tag;
      end else begin
        state_d     = DIV_ST_CALC;
        cnt_d       = CNT_W'(WIDTH);
        out_valid_d = 1'b0;
      end
    end

    if (flush) begin
      state_d     = DIV_ST_IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end

    busy_d = (state_d != DIV_ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= DIV_ST_IDLE;
      cnt_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      div_q        <= '0;
      op_q         <= '0;
      tag_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      div_q        <= div_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      busy_q       <= busy_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign busy       = busy_q;

endmodule
